// File: rtl/multicycle_ctrl_if.sv
// Control-unit boundary for the multicycle CPU: instruction/flag inputs,
// memory handshake, and the datapath strobes the controller drives.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_rd;
    logic       mem_wr;
    logic       ir_we;
    logic       pc_we;
    logic       pc_src;
    logic [1:0] ext_type;
    logic       alu_src_b;
    logic       reg_we;
    logic       illegal;
    logic [2:0] state;

    // Controller side
    modport slave (
        input  opcode, zero, mem_ready,
        output mem_rd, mem_wr, ir_we, pc_we, pc_src, ext_type,
               alu_src_b, reg_we, illegal, state
    );

    // Datapath / environment side
    modport master (
        output opcode, zero, mem_ready,
        input  mem_rd, mem_wr, ir_we, pc_we, pc_src, ext_type,
               alu_src_b, reg_we, illegal, state
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset controller: INIT -> FETCH -> DECODE -> EXEC
// -> (MEM) -> (WB). Strobes are decoded from the current state (and the
// handshake inputs), so an asynchronous reset clears them at once.
module multicycle_ctrl #(
    parameter logic [1:0] SIGNED_EXT   = 2'b00,
    parameter logic [1:0] UNSIGNED_EXT = 2'b01,
    parameter logic [1:0] LUI_EXT      = 2'b10
) (
    input  logic              clk,
    input  logic              rst_n,
    multicycle_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        INIT = 3'd0, FETCH = 3'd1, DECODE = 3'd2,
        EXEC = 3'd3, MEM = 3'd4, WB = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        RTYPE = 3'd0, IMM = 3'd1, LOAD = 3'd2, STORE = 3'd3, BRANCH = 3'd4
    } cls_e;

    state_e     state_q, state_d;
    cls_e       cls_q, cls_d;
    logic [1:0] ext_q, ext_d;
    logic       alu_q, alu_d;

    logic       dec_legal;
    cls_e       dec_cls;
    logic [1:0] dec_ext;

    logic mem_rd, mem_wr, ir_we, pc_we, pc_src, reg_we, illegal;

    // Opcode decode: instruction class and extender mode
    always_comb begin
        dec_legal = 1'b1;
        dec_cls   = RTYPE;
        dec_ext   = ext_q;
        case (bus.opcode)
            6'b000000: dec_cls = RTYPE;
            6'b001000,
            6'b001001: begin dec_cls = IMM;    dec_ext = SIGNED_EXT;   end
            6'b100011: begin dec_cls = LOAD;   dec_ext = SIGNED_EXT;   end
            6'b101011: begin dec_cls = STORE;  dec_ext = SIGNED_EXT;   end
            6'b000100: begin dec_cls = BRANCH; dec_ext = SIGNED_EXT;   end
            6'b001100,
            6'b001101: begin dec_cls = IMM;    dec_ext = UNSIGNED_EXT; end
            6'b001111: begin dec_cls = IMM;    dec_ext = LUI_EXT;      end
            default:   dec_legal = 1'b0;
        endcase
    end

    // Next-state and strobe generation
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        ext_d   = ext_q;
        alu_d   = alu_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        ir_we   = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 1'b0;
        reg_we  = 1'b0;
        illegal = 1'b0;
        case (state_q)
            INIT: state_d = FETCH;
            FETCH: begin
                mem_rd = 1'b1;
                if (bus.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (dec_legal) begin
                    // Operand-B select is latched here so it is stable from
                    // EXEC through MEM/WB.
                    cls_d   = dec_cls;
                    ext_d   = dec_ext;
                    alu_d   = (dec_cls == IMM) || (dec_cls == LOAD) || (dec_cls == STORE);
                    state_d = EXEC;
                end else begin
                    illegal = 1'b1;
                    state_d = FETCH;
                end
            end
            EXEC: begin
                case (cls_q)
                    RTYPE, IMM:  state_d = WB;
                    LOAD, STORE: state_d = MEM;
                    default: begin
                        pc_we   = bus.zero;
                        pc_src  = bus.zero;
                        state_d = FETCH;
                    end
                endcase
            end
            MEM: begin
                mem_rd = (cls_q == LOAD);
                mem_wr = (cls_q != LOAD);
                if (bus.mem_ready) state_d = (cls_q == LOAD) ? WB : FETCH;
            end
            WB: begin
                reg_we  = 1'b1;
                state_d = FETCH;
            end
            default: state_d = INIT;
        endcase
    end

    // State and decoded-instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cls_q   <= RTYPE;
            ext_q   <= SIGNED_EXT;
            alu_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            ext_q   <= ext_d;
            alu_q   <= alu_d;
        end
    end

    assign bus.mem_rd    = mem_rd;
    assign bus.mem_wr    = mem_wr;
    assign bus.ir_we     = ir_we;
    assign bus.pc_we     = pc_we;
    assign bus.pc_src    = pc_src;
    assign bus.reg_we    = reg_we;
    assign bus.illegal   = illegal;
    assign bus.ext_type  = ext_q;
    assign bus.alu_src_b = alu_q;
    assign bus.state     = state_q;

endmodule
